// File: rtl/regfile_pkg.sv
// Shared register-file write-back types and sizes.
// Used by the write-back arbiter and its LSU queue.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// LSU write-back queue with per-entry live bits and kill-by-address; no read latency (head is combinational).
// No internal backpressure: caller only pushes when count < DEPTH and only pops when count != 0.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  wb_req_t                  push_dat_i,
    input  logic                     pop_i,
    input  logic                     kill_vld_i,
    input  logic [REG_ADDR_W-1:0]    kill_addr_i,
    output wb_req_t                  head_dat_o,
    output logic                     head_live_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [NUM_REGS-1:0]      pend_mask_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t          mem_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Kill first, then push: a load pushed alongside a same-address ALU write is younger and stays live.
    always_comb begin
        live_d = live_q;
        if (kill_vld_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live_q[i] && (mem_q[i].addr == kill_addr_i)) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop_i) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            live_d[wr_ptr_q] = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pend_mask_o[mem_q[i].addr] = 1'b1;
            end
        end
        pend_mask_o[0] = 1'b0;
    end

    assign head_dat_o  = mem_q[rd_ptr_q];
    assign head_live_o = live_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU (priority, no backpressure) and queued LSU write-backs onto one registered write port; 1-cycle ALU, >=2-cycle LSU latency.
// LSU backpressure: lsu_wr_ready drops only when the queue is full, regardless of same-cycle pops.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_wr_valid,
    input  logic [REG_ADDR_W-1:0]         alu_wr_addr,
    input  logic [XLEN-1:0]               alu_wr_data,
    input  logic                          lsu_wr_valid,
    output logic                          lsu_wr_ready,
    input  logic [REG_ADDR_W-1:0]         lsu_wr_addr,
    input  logic [XLEN-1:0]               lsu_wr_data,
    output logic                          reg_write_en,
    output logic [REG_ADDR_W-1:0]         write_reg_addr,
    output logic [XLEN-1:0]               write_data,
    output logic [NUM_REGS-1:0]           pend_mask,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  alu_sel;
    logic                  push;
    logic                  pop;
    wb_req_t               push_dat;
    wb_req_t               head_dat;
    logic                  head_live;

    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;

    // Writes to x0 are architecturally void, so they neither win arbitration nor enter the queue.
    assign alu_sel      = alu_wr_valid && (alu_wr_addr != '0);
    assign lsu_wr_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign push         = lsu_wr_valid && lsu_wr_ready && (lsu_wr_addr != '0);
    assign pop          = !alu_sel && (fifo_count != '0);
    assign push_dat     = '{addr: lsu_wr_addr, data: lsu_wr_data};

    wb_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_dat_i  (push_dat),
        .pop_i       (pop),
        .kill_vld_i  (alu_sel),
        .kill_addr_i (alu_wr_addr),
        .head_dat_o  (head_dat),
        .head_live_o (head_live),
        .count_o     (fifo_count),
        .pend_mask_o (pend_mask)
    );

    always_comb begin
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (alu_sel) begin
            we_d   = 1'b1;
            addr_d = alu_wr_addr;
            data_d = alu_wr_data;
        end else if (pop && head_live) begin
            we_d   = 1'b1;
            addr_d = head_dat.addr;
            data_d = head_dat.data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign reg_write_en   = we_q;
    assign write_reg_addr = addr_q;
    assign write_data     = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, randomized traffic against a queue model, reset corner case.
module tb_regfile_wb_arbiter;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_wr_valid;
    logic [4:0]  alu_wr_addr;
    logic [31:0] alu_wr_data;
    logic        lsu_wr_valid;
    logic        lsu_wr_ready;
    logic [4:0]  lsu_wr_addr;
    logic [31:0] lsu_wr_data;
    logic        reg_write_en;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_data;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_wr_valid   (alu_wr_valid),
        .alu_wr_addr    (alu_wr_addr),
        .alu_wr_data    (alu_wr_data),
        .lsu_wr_valid   (lsu_wr_valid),
        .lsu_wr_ready   (lsu_wr_ready),
        .lsu_wr_addr    (lsu_wr_addr),
        .lsu_wr_data    (lsu_wr_data),
        .reg_write_en   (reg_write_en),
        .write_reg_addr (write_reg_addr),
        .write_data     (write_data),
        .pend_mask      (pend_mask),
        .fifo_count     (fifo_count)
    );

    typedef struct {
        logic        av; logic [4:0] aa; logic [31:0] ad;
        logic        lv; logic [4:0] la; logic [31:0] ld;
        logic        ew; logic [4:0] ea; logic [31:0] ed;
        logic [31:0] ep; logic [2:0] ec; logic er;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        live;
    } ent_t;

    vec_t tbl[$];
    ent_t q[$];

    function automatic vec_t mk(int av, int aa, int ad, int lv, int la, int ld,
                                int ew, int ea, int ed, int ep, int ec, int er);
        vec_t v;
        v.av = 1'(av); v.aa = 5'(aa); v.ad = 32'(ad);
        v.lv = 1'(lv); v.la = 5'(la); v.ld = 32'(ld);
        v.ew = 1'(ew); v.ea = 5'(ea); v.ed = 32'(ed);
        v.ep = 32'(ep); v.ec = 3'(ec); v.er = 1'(er);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        alu_wr_valid = av; alu_wr_addr = aa; alu_wr_data = ad;
        lsu_wr_valid = lv; lsu_wr_addr = la; lsu_wr_data = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                             input logic [31:0] ep, input logic [2:0] ec, input logic er);
        chk({tag, " we"}, 32'(reg_write_en), 32'(ew));
        if (ew) begin
            chk({tag, " addr"}, 32'(write_reg_addr), 32'(ea));
            chk({tag, " data"}, write_data, ed);
        end
        chk({tag, " pend"}, pend_mask, ep);
        chk({tag, " count"}, 32'(fifo_count), 32'(ec));
        chk({tag, " ready"}, 32'(lsu_wr_ready), 32'(er));
    endtask

    // Reference: ALU wins if addr!=0 and kills matching queued loads; otherwise the oldest entry retires.
    task automatic mstep(input string tag, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        logic        rdy, ew;
        logic [4:0]  ea;
        logic [31:0] ed, ep;
        ent_t        e;
        rdy = (q.size() < D);
        ew = 1'b0; ea = '0; ed = '0;
        if (av && aa != 0) begin
            ew = 1'b1; ea = aa; ed = ad;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].a == aa) q[i].live = 1'b0;
            end
        end else if (q.size() != 0) begin
            e  = q.pop_front();
            ew = e.live; ea = e.a; ed = e.d;
        end
        if (lv && rdy && la != 0) begin
            e.a = la; e.d = ld; e.live = 1'b1;
            q.push_back(e);
        end
        drive(av, aa, ad, lv, la, ld);
        ep = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].live) ep[q[i].a] = 1'b1;
        end
        check_out(tag, ew, ea, ed, ep, 3'(q.size()), 1'(q.size() < D));
    endtask

    initial begin
        reset = 1'b0;
        alu_wr_valid = 0; alu_wr_addr = '0; alu_wr_data = '0;
        lsu_wr_valid = 0; lsu_wr_addr = '0; lsu_wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst we", 32'(reg_write_en), 0);
        chk("rst addr", 32'(write_reg_addr), 0);
        chk("rst data", write_data, 0);
        check_out("rst", 1'b0, '0, '0, '0, '0, 1'b1);
        reset = 1'b1;

        // ALU single write
        tbl.push_back(mk(1, 5, 'h11, 0, 0, 0,        1, 5, 'h11,   0,      0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0,      0,      0, 1));
        // LSU single write: pend in N+1, write in N+2
        tbl.push_back(mk(0, 0, 0, 1, 7, 'hAB,        0, 0, 0,      'h80,   1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           1, 7, 'hAB,   0,      0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0,      0,      0, 1));
        // ALU burst of 6 while LSU offers 5; queue fills at 4
        tbl.push_back(mk(1, 1, 'h101, 1, 10, 'h200,  1, 1, 'h101,  'h0400, 1, 1));
        tbl.push_back(mk(1, 2, 'h102, 1, 11, 'h201,  1, 2, 'h102,  'h0C00, 2, 1));
        tbl.push_back(mk(1, 3, 'h103, 1, 12, 'h202,  1, 3, 'h103,  'h1C00, 3, 1));
        tbl.push_back(mk(1, 4, 'h104, 1, 13, 'h203,  1, 4, 'h104,  'h3C00, 4, 0));
        tbl.push_back(mk(1, 5, 'h105, 1, 14, 'h204,  1, 5, 'h105,  'h3C00, 4, 0));
        tbl.push_back(mk(1, 6, 'h106, 1, 14, 'h204,  1, 6, 'h106,  'h3C00, 4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 14, 'h204,      1, 10, 'h200, 'h3800, 3, 1));
        tbl.push_back(mk(0, 0, 0, 1, 14, 'h204,      1, 11, 'h201, 'h7000, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           1, 12, 'h202, 'h6000, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           1, 13, 'h203, 'h4000, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           1, 14, 'h204, 0,      0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0,      0,      0, 1));
        // ALU supersedes queued load to x9
        tbl.push_back(mk(0, 0, 0, 1, 9, 1,           0, 0, 0,      'h200,  1, 1));
        tbl.push_back(mk(1, 9, 2, 0, 0, 0,           1, 9, 2,      0,      1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0,      0,      0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0,      0,      0, 1));
        // x0 requests from both sources
        tbl.push_back(mk(1, 0, 'h66, 1, 0, 'h55,     0, 0, 0,      0,      0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0,      0,      0, 1));
        // Same-cycle ALU x3 and new load x3: older load killed, new load live
        tbl.push_back(mk(0, 0, 0, 1, 3, 'h30,        0, 0, 0,      'h8,    1, 1));
        tbl.push_back(mk(1, 3, 'h31, 1, 3, 'h32,     1, 3, 'h31,   'h8,    2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0,      'h8,    1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           1, 3, 'h32,   0,      0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0,      0,      0, 1));
        // ALU to x0 does not block a pop
        tbl.push_back(mk(0, 0, 0, 1, 4, 'h40,        0, 0, 0,      'h10,   1, 1));
        tbl.push_back(mk(1, 0, 'h77, 0, 0, 0,        1, 4, 'h40,   0,      0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0,      0,      0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld);
            check_out($sformatf("vec%0d", i), tbl[i].ew, tbl[i].ea, tbl[i].ed,
                      tbl[i].ep, tbl[i].ec, tbl[i].er);
        end

        // Randomized traffic over a small address set so kills and collisions are frequent
        for (int c = 0; c < 600; c++) begin
            mstep($sformatf("rnd%0d", c),
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 9) < 6),  5'($urandom_range(0, 7)), $urandom);
        end
        for (int c = 0; c < 6; c++) begin
            mstep($sformatf("drain%0d", c), 1'b0, '0, '0, 1'b0, '0, '0);
        end

        // Queue 3 entries behind an ALU burst, then reset mid-operation
        for (int c = 0; c < 3; c++) begin
            mstep($sformatf("fill%0d", c), 1'b1, 5'd1, 32'(c), 1'b1, 5'(20 + c), 32'('h500 + c));
        end
        alu_wr_valid = 0; lsu_wr_valid = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst2 addr", 32'(write_reg_addr), 0);
        chk("rst2 data", write_data, 0);
        check_out("rst2", 1'b0, '0, '0, '0, '0, 1'b1);
        q.delete();
        @(posedge clk);
        #1;
        check_out("rst2 hold", 1'b0, '0, '0, '0, '0, 1'b1);
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check_out("post rst1", 1'b0, '0, '0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check_out("post rst2", 1'b0, '0, '0, '0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, default 4, number of queued LSU write-back entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: alu_wr_valid  input  1  ALU write-back request this cycle; no backpressure.
REQ-005 SHALL have port: alu_wr_addr  input  5  ALU destination register.
REQ-006 SHALL have port: alu_wr_data  input  32  ALU result.
REQ-007 SHALL have port: lsu_wr_valid  input  1  load-unit write-back request.
REQ-008 SHALL have port: lsu_wr_ready  output  1  arbiter can accept an LSU request.
REQ-009 SHALL have port: lsu_wr_addr  input  5  load destination register.
REQ-010 SHALL have port: lsu_wr_data  input  32  load data.
REQ-011 SHALL have port: reg_write_en  output  1  register-file write enable, registered.
REQ-012 SHALL have port: write_reg_addr  output  5  register-file write address, registered.
REQ-013 SHALL have port: write_data  output  32  register-file write data, registered.
REQ-014 SHALL have port: pend_mask  output  32  bit i set while a live queued LSU write targets register i.
REQ-015 SHALL have port: fifo_count  output  clog2(FIFO_DEPTH)+1  number of occupied FIFO slots (live or killed).

Function
REQ-016 SHALL drive the register-file write port from a single output register; any write selected in cycle N is visible on reg_write_en/write_reg_addr/write_data during cycle N+1 only.
REQ-017 SHALL give the ALU absolute priority: alu_wr_valid with alu_wr_addr!=0 selects the ALU write in that cycle.
REQ-018 SHALL ignore alu_wr_valid with alu_wr_addr==0 (no write, no FIFO pop blocked).
REQ-019 SHALL assert lsu_wr_ready exactly when fifo_count < FIFO_DEPTH, independent of lsu_wr_valid and of a same-cycle pop.
REQ-020 SHALL push {addr,data} into the FIFO on lsu_wr_valid && lsu_wr_ready when lsu_wr_addr!=0; with lsu_wr_addr==0, SHALL complete the handshake and discard the request.
REQ-021 SHALL pop the FIFO head in any cycle where no ALU write is selected and the FIFO is non-empty; a live head produces a write, a killed head produces no write (reg_write_en=0).
REQ-022 SHALL never pop an entry in the cycle it is pushed; minimum LSU latency is acceptance in cycle N, write visible in cycle N+2.
REQ-023 SHALL support simultaneous push and pop (count unchanged), pointers wrapping modulo FIFO_DEPTH.
REQ-024 SHALL, when an ALU write to register X is selected, mark every live FIFO entry with addr X as killed in the same edge (ALU write is younger and supersedes queued loads).
REQ-025 SHALL, when a push of addr X coincides with a selected ALU write to X, store the new entry as live (load is younger).
REQ-026 SHALL compute pend_mask combinationally from live FIFO entries; pend_mask[0] SHALL always be 0.
REQ-027 SHALL hold reg_write_en=0 in any cycle following one with no selected write.

Reset
REQ-028 SHALL, while reset is low, force reg_write_en=0, write_reg_addr=0, write_data=0, FIFO pointers and count=0, all entry valid/live bits=0; pend_mask=0, lsu_wr_ready=1.
REQ-029 SHALL discard queued entries on reset assertion mid-operation; no write SHALL issue in the first cycle after reset release.
REQ-030 SHALL NOT require reset of FIFO data storage.

Structure
REQ-031 SHALL take XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and typedef wb_req_t {addr, data} from shared package regfile_pkg.
REQ-032 SHALL implement queue storage, pointers and count in one sub-module wb_fifo, with per-entry live bits and kill-by-address input.

Verification
REQ-033 SHALL test: ALU valid addr=5 data=0x11 in cycle 1 -> reg_write_en=1, addr 5, data 0x11 in cycle 2 only.
REQ-034 SHALL test: LSU addr=7 data=0xAB accepted cycle 1, ALU idle -> write x7=0xAB in cycle 3, pend_mask[7]=1 in cycle 2, 0 in cycle 3.
REQ-035 SHALL test: ALU valid every cycle for 6 cycles while LSU offers 5 requests -> ready drops after 4 accepts, no LSU write during ALU burst, queued writes drain in order afterward.
REQ-036 SHALL test: LSU x9=0x1 queued, then ALU x9=0x2 -> x9=0x2 written, killed entry pops with reg_write_en=0, pend_mask[9] clears at kill.
REQ-037 SHALL test: LSU addr=0 and ALU addr=0 requests -> handshake completes, no write, fifo_count stays 0.
REQ-038 SHALL test: reset low with 3 entries queued -> all outputs at reset values, no write after release, lsu_wr_ready=1.
